// File: rtl/mvm_arbiter.sv
// Round-robin arbiter sharing one mvm unit between the forward (A) and backprop (B) sequencers.
// Optional watchdog on the mvm handshake: define MVM_ARBITER_TIMEOUT_EN.
module mvm_arbiter #(
    parameter int MATRIX_WIDTH      = 4,
    parameter int MATRIX_HEIGHT     = 5,
    parameter int VECTOR_CELL_WIDTH = 8,
    parameter int MATRIX_CELL_WIDTH = 8,
    parameter int RESULT_CELL_WIDTH = 8,
    parameter int TIMEOUT           = 255,
    localparam int VW = MATRIX_HEIGHT * VECTOR_CELL_WIDTH,
    localparam int MW = MATRIX_WIDTH * MATRIX_HEIGHT * MATRIX_CELL_WIDTH,
    localparam int RW = MATRIX_WIDTH * RESULT_CELL_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_a,
    input  logic          req_b,
    input  logic [VW-1:0] vector_a,
    input  logic [VW-1:0] vector_b,
    input  logic [MW-1:0] matrix_a,
    input  logic [MW-1:0] matrix_b,
    output logic          grant_a,
    output logic          grant_b,
    output logic          ack_a,
    output logic          ack_b,
    output logic [RW-1:0] result,
    output logic          error,
    output logic          mvm_start,
    output logic [VW-1:0] mvm_vector,
    output logic [MW-1:0] mvm_matrix,
    input  logic [RW-1:0] mvm_result,
    input  logic          mvm_valid,
    input  logic          mvm_error
);

    typedef enum logic [2:0] {IDLE, LAUNCH, ARM, BUSY, RESP} state_t;

    state_t state, state_nx;
    logic   owner;      // 0 = A, 1 = B
    logic   prio;       // requester favoured on a tie
    logic   any_req, sel_b, waiting, wd_expired;

    if (TIMEOUT < 1) begin : g_timeout_chk
        $error("mvm_arbiter: TIMEOUT must be at least 1");
    end

    assign any_req = req_a | req_b;
    assign sel_b   = req_b & (~req_a | prio);
    assign waiting = (state == ARM) || (state == BUSY);

`ifdef MVM_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wd_cnt;

    always_ff @(posedge clk) begin
        if (!rst)
            wd_cnt <= '0;
        else if (state == LAUNCH)
            wd_cnt <= '0;
        else if (waiting && !wd_expired)
            wd_cnt <= wd_cnt + CW'(1);
    end

    assign wd_expired = waiting && (wd_cnt >= CW'(TIMEOUT));
`else
    assign wd_expired = 1'b0;
`endif

    // ARM swallows the valid level left high by the previous operation.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_req) state_nx = LAUNCH;
            LAUNCH:  state_nx = ARM;
            ARM: begin
                if (wd_expired)      state_nx = RESP;
                else if (!mvm_valid) state_nx = BUSY;
            end
            BUSY:    if (mvm_valid || wd_expired) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            prio       <= 1'b0;
            mvm_vector <= '0;
            mvm_matrix <= '0;
            result     <= '0;
            error      <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && any_req) begin
                owner      <= sel_b;
                mvm_vector <= sel_b ? vector_b : vector_a;
                mvm_matrix <= sel_b ? matrix_b : matrix_a;
            end
            if (state == BUSY && mvm_valid) begin
                result <= mvm_result;
                error  <= mvm_error;
            end else if (wd_expired) begin
                result <= '0;
                error  <= 1'b1;
            end
            if (state == RESP)
                prio <= ~owner;
        end
    end

    assign mvm_start = (state == LAUNCH);
    assign grant_a   = (state != IDLE) & ~owner;
    assign grant_b   = (state != IDLE) &  owner;
    assign ack_a     = (state == RESP) & ~owner;
    assign ack_b     = (state == RESP) &  owner;

endmodule

// File: tb/tb_mvm_arbiter.sv
// Bench for mvm_arbiter: 10-cycle mvm stub, transaction-level reference model, directed phases.
module tb_mvm_arbiter;

    localparam int MWD = 4, MH = 5, VC = 8, MC = 8, RC = 8;
`ifdef MVM_ARBITER_TIMEOUT_EN
    localparam int TO = 20;
`else
    localparam int TO = 255;
`endif
    localparam int VW = MH * VC, MWW = MWD * MH * MC, RW = MWD * RC;

    logic clk = 0, rst = 0, req_a = 0, req_b = 0;
    logic [VW-1:0]  vector_a = '0, vector_b = '0;
    logic [MWW-1:0] matrix_a = '0, matrix_b = '0;
    logic grant_a, grant_b, ack_a, ack_b, error, mvm_start, mvm_valid, mvm_error;
    logic [RW-1:0]  result, mvm_result;
    logic [VW-1:0]  mvm_vector;
    logic [MWW-1:0] mvm_matrix;

    always #5 clk = ~clk;

    mvm_arbiter #(.MATRIX_WIDTH(MWD), .MATRIX_HEIGHT(MH), .VECTOR_CELL_WIDTH(VC),
                  .MATRIX_CELL_WIDTH(MC), .RESULT_CELL_WIDTH(RC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b),
        .vector_a(vector_a), .vector_b(vector_b), .matrix_a(matrix_a), .matrix_b(matrix_b),
        .grant_a(grant_a), .grant_b(grant_b), .ack_a(ack_a), .ack_b(ack_b),
        .result(result), .error(error), .mvm_start(mvm_start),
        .mvm_vector(mvm_vector), .mvm_matrix(mvm_matrix),
        .mvm_result(mvm_result), .mvm_valid(mvm_valid), .mvm_error(mvm_error));

    // Cell (row i, col j) of a matrix sits at index i*MWD+j; result cell j = sum_i v[i]*m[i][j].
    function automatic logic [RW-1:0] mvm_ref(input logic [VW-1:0] v, input logic [MWW-1:0] m);
        logic [RW-1:0] r;
        int acc;
        r = '0;
        for (int j = 0; j < MWD; j++) begin
            acc = 0;
            for (int i = 0; i < MH; i++)
                acc += int'(v[i*VC +: VC]) * int'(m[(i*MWD+j)*MC +: MC]);
            r[j*RC +: RC] = acc[RC-1:0];
        end
        return r;
    endfunction

    // mvm stub: valid rises 10 cycles after the start edge and stays high until the next start.
    bit err_inj = 0, stall = 0, st_busy;
    int st_cnt;
    always @(posedge clk) begin
        if (!rst) begin
            mvm_valid <= 0; mvm_error <= 0; mvm_result <= '0; st_busy <= 0; st_cnt <= 0;
        end else if (mvm_start) begin
            mvm_valid <= 0; st_busy <= 1; st_cnt <= 10;
            mvm_result <= mvm_ref(mvm_vector, mvm_matrix);
            mvm_error <= err_inj;
        end else if (st_busy && !stall) begin
            if (st_cnt == 1) begin mvm_valid <= 1; st_busy <= 0; end
            else st_cnt <= st_cnt - 1;
        end
    end

    int cyc = 0;
    initial forever begin @(posedge clk); cyc++; end

    int checks = 0, errors = 0;
    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: owner of the current transaction, round-robin pointer, pending result.
    int m_owner = -1, m_t = 0;
    bit m_prio = 0, m_start = 0, m_low = 0, m_ack = 0, m_perr = 0, m_err = 0, rst_pend = 1;
    logic [RW-1:0]  m_pres = '0, m_res = '0;
    logic [VW-1:0]  m_vec = '0;
    logic [MWW-1:0] m_mat = '0;
    int start_q[$], ack_q[$], own_q[$];
    bit gb_seen = 0;

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (rst_pend) begin
                chk("rst_ctrl", 256'({grant_a, grant_b, ack_a, ack_b, mvm_start, error}), 256'(0));
                chk("rst_data", 256'({result, mvm_vector, mvm_matrix}), 256'(0));
                m_owner = -1; m_prio = 0; m_start = 0; m_ack = 0; m_res = '0; m_err = 0;
            end else begin
                chk("grant_a", 256'(grant_a), 256'(m_owner == 0));
                chk("grant_b", 256'(grant_b), 256'(m_owner == 1));
                chk("mvm_start", 256'(mvm_start), 256'(m_start));
                chk("ack_a", 256'(ack_a), 256'(m_ack && m_owner == 0));
                chk("ack_b", 256'(ack_b), 256'(m_ack && m_owner == 1));
                if (m_start) begin
                    chk("mvm_vector", 256'(mvm_vector), 256'(m_vec));
                    chk("mvm_matrix", 256'(mvm_matrix), 256'(m_mat));
                end
                if (m_ack) begin m_res = m_pres; m_err = m_perr; end
                chk("result", 256'(result), 256'(m_res));
                chk("error", 256'(error), 256'(m_err));
            end
            if (mvm_start) start_q.push_back(cyc);
            if (ack_a || ack_b) begin ack_q.push_back(cyc); own_q.push_back(ack_b ? 1 : 0); end
            if (grant_b) gb_seen = 1;
            // advance the model with this cycle's inputs
            if (m_ack) begin
                m_prio = (m_owner == 0); m_owner = -1; m_ack = 0;
            end else if (m_owner < 0) begin
                if (req_a || req_b) begin
                    m_owner = (req_a && req_b) ? (m_prio ? 1 : 0) : (req_b ? 1 : 0);
                    m_vec = m_owner == 1 ? vector_b : vector_a;
                    m_mat = m_owner == 1 ? matrix_b : matrix_a;
                    m_pres = mvm_ref(m_vec, m_mat);
                    m_start = 1; m_low = 0; m_t = 0;
                end
            end else if (m_start) begin
                m_start = 0; m_perr = err_inj;
            end else begin
                m_t++;
                if (m_low && mvm_valid) m_ack = 1;
`ifdef MVM_ARBITER_TIMEOUT_EN
                else if (m_t > TO) begin m_ack = 1; m_pres = '0; m_perr = 1; end
`endif
                if (!mvm_valid) m_low = 1;
            end
            rst_pend = !rst;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Wait for n acks; optionally drop the acked request. Returns in the cycle after the last ack.
    task automatic wait_acks(input int n, input bit drop, input int maxc);
        int got = 0, c = 0;
        while (got < n && c < maxc) begin
            tick(); c++;
            if (ack_a) begin got++; if (drop) req_a = 0; end
            if (ack_b) begin got++; if (drop) req_b = 0; end
        end
        if (got < n) begin
            checks++; errors++;
            $display("FAIL ack_wait: got %0d acks expected %0d within %0d cycles", got, n, maxc);
        end
        tick();
    endtask

    logic [MWW-1:0] ident, ones, colm;
    int t0, n0, na;

    initial begin
        ident = '0; ones = '0; colm = '0;
        for (int i = 0; i < MH; i++)
            for (int j = 0; j < MWD; j++) begin
                if (i == j) ident[(i*MWD+j)*MC +: MC] = 8'd1;
                ones[(i*MWD+j)*MC +: MC] = 8'd1;
                colm[(i*MWD+j)*MC +: MC] = 8'(j + 1);
            end
        repeat (3) tick();

        // single request A: identity x ones
        rst = 1; vector_a = {MH{8'h01}}; matrix_a = ident; req_a = 1; t0 = cyc; gb_seen = 0;
        wait_acks(1, 1, 100);
        chk("p1_start_lat", 256'(start_q[start_q.size()-1] - t0), 256'(1));
        chk("p1_ack_lat", 256'(ack_q[ack_q.size()-1] - start_q[start_q.size()-1]), 256'(12));
        chk("p1_result", 256'(result), 256'(32'h01010101));
        chk("p1_no_grant_b", 256'(gb_seen), 256'(0));

        // simultaneous requests after reset: A, then B with no gap
        rst = 0; tick(); rst = 1;
        vector_b = {MH{8'h02}}; matrix_b = ident; req_a = 1; req_b = 1; n0 = own_q.size();
        wait_acks(2, 1, 200);
        chk("p2_first", 256'(own_q[n0]), 256'(0));
        chk("p2_second", 256'(own_q[n0+1]), 256'(1));
        chk("p2_b_gap", 256'(start_q[start_q.size()-1] - ack_q[ack_q.size()-2]), 256'(2));
        chk("p2_result", 256'(result), 256'(32'h02020202));
        req_a = 1; req_b = 1; n0 = own_q.size();
        wait_acks(2, 1, 200);
        chk("p2_prio_back_a", 256'(own_q[n0]), 256'(0));

        // fairness with both requests held
        vector_a = 40'h0504030201; matrix_a = ones; vector_b = {MH{8'h01}}; matrix_b = colm;
        req_a = 1; req_b = 1; n0 = own_q.size();
        wait_acks(6, 0, 500);
        req_a = 0; req_b = 0;
        for (int i = 0; i < 6; i++) chk("p3_alternate", 256'(own_q[n0+i]), 256'(i % 2));
        chk("p3_result", 256'(result), 256'(32'h140f0a05));

        // error pass-through; A's operands change after grant
        err_inj = 1; req_a = 1;
        repeat (2) tick();
        vector_a = 40'hffeeddccbb;
        wait_acks(1, 1, 100);
        chk("p4_err_set", 256'(error), 256'(1));
        chk("p4_result", 256'(result), 256'(32'h0f0f0f0f));
        err_inj = 0; vector_a = 40'h0504030201; req_b = 1;
        wait_acks(1, 1, 100);
        chk("p4_err_clear", 256'(error), 256'(0));

        // reset during BUSY abandons the operation
        req_a = 1; na = ack_q.size();
        repeat (6) tick();
        rst = 0; req_a = 0; tick();
        chk("p5_outputs", 256'({grant_a, grant_b, ack_a, ack_b, mvm_start, error, result}), 256'(0));
        rst = 1; tick(); tick();
        chk("p5_no_ack", 256'(ack_q.size() - na), 256'(0));
        req_b = 1;
        wait_acks(1, 1, 100);
        chk("p5_recover", 256'(own_q[own_q.size()-1]), 256'(1));
        chk("p5_result", 256'(result), 256'(32'h140f0a05));

`ifdef MVM_ARBITER_TIMEOUT_EN
        // watchdog: mvm never answers
        stall = 1; req_a = 1;
        wait_acks(1, 1, 100);
        chk("p6_to_lat", 256'(ack_q[ack_q.size()-1] - start_q[start_q.size()-1]), 256'(22));
        chk("p6_to_err", 256'(error), 256'(1));
        chk("p6_to_result", 256'(result), 256'(0));
        stall = 0;
`endif

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

endmodule
